// File: rtl/alu_sequencer.sv
// Issue-side sequencer for the combinational ALU: runs single-cycle ops in one
// execute cycle and unsigned 8x8 multiply as eight shift-add passes through the adder.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] op_code,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic       use_carry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_lo,
  output logic [7:0] res_hi,
  output logic       res_wb,
  output logic       res_err,
  output logic [3:0] flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [7:0] alu_cins,
  output logic       alu_oe,
  output logic       alu_cin,
  input  logic [7:0] alu_out,
  input  logic       alu_cout,
  input  logic       alu_ovf,
  input  logic       alu_cmp
);

  localparam logic [7:0] CINS_ADD = 8'h00;
  localparam logic [3:0] OP_MUL   = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_e;

  state_e     state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic [2:0] opIdx_q, opIdx_d;
  logic       useCarry_q, useCarry_d;
  logic [7:0] acc_q, acc_d, mplr_q, mplr_d;
  logic [2:0] count_q, count_d;
  logic [7:0] resLo_q, resLo_d, resHi_q, resHi_d;
  logic       resWb_q, resWb_d, resErr_q, resErr_d;
  logic [3:0] flags_q, flags_d;
  logic [7:0] accNext, mplrNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      opIdx_q    <= '0;
      useCarry_q <= 1'b0;
      acc_q      <= '0;
      mplr_q     <= '0;
      count_q    <= '0;
      resLo_q    <= '0;
      resHi_q    <= '0;
      resWb_q    <= 1'b0;
      resErr_q   <= 1'b0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      opIdx_q    <= opIdx_d;
      useCarry_q <= useCarry_d;
      acc_q      <= acc_d;
      mplr_q     <= mplr_d;
      count_q    <= count_d;
      resLo_q    <= resLo_d;
      resHi_q    <= resHi_d;
      resWb_q    <= resWb_d;
      resErr_q   <= resErr_d;
      flags_q    <= flags_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    opIdx_d    = opIdx_q;
    useCarry_d = useCarry_q;
    acc_d      = acc_q;
    mplr_d     = mplr_q;
    count_d    = count_q;
    resLo_d    = resLo_q;
    resHi_d    = resHi_q;
    resWb_d    = resWb_q;
    resErr_d   = resErr_q;
    flags_d    = flags_q;
    accNext    = '0;
    mplrNext   = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_cins   = '0;
    alu_oe     = 1'b0;
    alu_cin    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          a_d        = op_a;
          b_d        = op_b;
          opIdx_d    = op_code[2:0];
          useCarry_d = use_carry;
          if (!op_code[3]) begin
            state_d = EXEC;
          end else if (op_code == OP_MUL) begin
            acc_d   = '0;
            mplr_d  = op_b;
            count_d = '0;
            state_d = MUL;
          end else begin
            // Reserved opcode: report an error without touching the flags.
            resLo_d  = '0;
            resHi_d  = '0;
            resWb_d  = 1'b0;
            resErr_d = 1'b1;
            state_d  = DONE;
          end
        end
      end
      EXEC: begin
        alu_a    = a_q;
        alu_b    = b_q;
        alu_cins = {5'b0, opIdx_q};
        alu_oe   = 1'b1;
        alu_cin  = useCarry_q & flags_q[0];
        resLo_d  = alu_out;
        resHi_d  = '0;
        resWb_d  = ~alu_cmp;
        resErr_d = 1'b0;
        flags_d  = {alu_ovf, alu_out[7], alu_out == 8'h00, alu_cout};
        state_d  = DONE;
      end
      MUL: begin
        alu_a    = acc_q;
        alu_b    = a_q;
        alu_cins = CINS_ADD;
        alu_oe   = 1'b1;
        // Conditionally add the multiplicand, then shift {acc,mplr} right by one.
        if (mplr_q[0]) begin
          accNext  = {alu_cout, alu_out[7:1]};
          mplrNext = {alu_out[0], mplr_q[7:1]};
        end else begin
          accNext  = {1'b0, acc_q[7:1]};
          mplrNext = {acc_q[0], mplr_q[7:1]};
        end
        acc_d   = accNext;
        mplr_d  = mplrNext;
        count_d = count_q + 3'd1;
        if (count_q == 3'd7) begin
          resHi_d  = accNext;
          resLo_d  = mplrNext;
          resWb_d  = 1'b1;
          resErr_d = 1'b0;
          flags_d  = {1'b0, accNext[7], {accNext, mplrNext} == 16'h0000, accNext != 8'h00};
          state_d  = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign op_ready  = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign res_lo    = resLo_q;
  assign res_hi    = resHi_q;
  assign res_wb    = resWb_q;
  assign res_err   = resErr_q;
  assign flags     = flags_q;

endmodule
